// File: rtl/pc_next_gen_if.sv
// pc_next_gen_if
// Groups the fetch-side and EX-side signals of the next-PC generator.
//   master : the generator (pc_next_gen) - drives pc_next, stall, flush,
//            pred_taken, pred_target, branch_cnt, mispred_cnt.
//   slave  : the surrounding pipeline - drives pc_cur, hazard_stall,
//            imem_busy and the resolved EX branch information.
interface pc_next_gen_if;
  // Fetch side
  logic [31:0] pc_cur;
  logic        hazard_stall;
  logic        imem_busy;
  // Resolved control-flow instruction in EX
  logic        ex_valid;
  logic        ex_is_jump;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  // Generator outputs
  logic [31:0] pc_next;
  logic        stall;
  logic        flush;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  modport master (
    input  pc_cur, hazard_stall, imem_busy,
    input  ex_valid, ex_is_jump, ex_pc, ex_taken, ex_target,
    input  ex_pred_taken, ex_pred_target,
    output pc_next, stall, flush, pred_taken, pred_target,
    output branch_cnt, mispred_cnt
  );

  modport slave (
    output pc_cur, hazard_stall, imem_busy,
    output ex_valid, ex_is_jump, ex_pc, ex_taken, ex_target,
    output ex_pred_taken, ex_pred_target,
    input  pc_next, stall, flush, pred_taken, pred_target,
    input  branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/pc_next_gen.sv
// pc_next_gen
// Next-PC generator for the fetch stage. Looks up pc_cur in a direct-mapped
// BTB with 2-bit saturating counters, redirects fetch on EX mispredictions
// (flushing younger stages), and counts resolved branches / mispredictions.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : pc_next_gen_if.master (fetch inputs, EX resolution inputs,
//              pc_next/stall/flush/prediction outputs, statistics counters)
module pc_next_gen #(
  parameter int BTB_ENTRIES = 16
) (
  input logic             clk,
  input logic             rst,
  pc_next_gen_if.master   bus
);
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 32 - IDX - 2;

  // BTB storage; read combinationally so it maps to distributed RAM/regs.
  logic [BTB_ENTRIES-1:0] valid_reg;
  logic [TAG_W-1:0]       tag_reg    [BTB_ENTRIES];
  logic [31:0]            target_reg [BTB_ENTRIES];
  logic [1:0]             ctr_reg    [BTB_ENTRIES];
  logic [31:0]            branch_cnt_reg;
  logic [31:0]            mispred_cnt_reg;

  // ---------------- Lookup on pc_cur ----------------
  logic [IDX-1:0]   lu_idx;
  logic [TAG_W-1:0] lu_tag;
  logic             lu_hit;
  logic [31:0]      pc_plus4;

  assign lu_idx   = bus.pc_cur[IDX+1:2];
  assign lu_tag   = bus.pc_cur[31:IDX+2];
  assign lu_hit   = valid_reg[lu_idx] && (tag_reg[lu_idx] == lu_tag);
  assign pc_plus4 = bus.pc_cur + 32'd4;

  // Predictions are suppressed during reset because the BTB still holds
  // pre-reset contents until the reset edge.
  logic pred_taken_c;
  assign pred_taken_c    = !rst && lu_hit && ctr_reg[lu_idx][1];
  assign bus.pred_taken  = pred_taken_c;
  assign bus.pred_target = (!rst && lu_hit) ? target_reg[lu_idx] : pc_plus4;

  // ---------------- Mispredict / redirect ----------------
  logic mis;
  logic redirect;
  assign mis = bus.ex_valid &&
               ((bus.ex_taken != bus.ex_pred_taken) ||
                (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
  assign redirect = !rst && mis;

  always_comb begin
    bus.pc_next = pc_plus4;
    if (rst) begin
      bus.pc_next = pc_plus4;
    end else if (mis) begin
      bus.pc_next = bus.ex_taken ? bus.ex_target : (bus.ex_pc + 32'd4);
    end else if (pred_taken_c) begin
      bus.pc_next = bus.pred_target;
    end
  end

  // A redirect overrides any stall so the corrected PC is loaded.
  assign bus.stall = !rst && !mis && (bus.hazard_stall || bus.imem_busy);
  assign bus.flush = redirect;

  // ---------------- BTB update ----------------
  logic [IDX-1:0]   up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [1:0]       up_ctr;

  assign up_idx = bus.ex_pc[IDX+1:2];
  assign up_tag = bus.ex_pc[31:IDX+2];
  assign up_hit = valid_reg[up_idx] && (tag_reg[up_idx] == up_tag);
  assign up_ctr = ctr_reg[up_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        ctr_reg[i] <= 2'b01;
      end
    end else if (bus.ex_valid) begin
      if (!up_hit) begin
        if (bus.ex_taken) begin
          valid_reg[up_idx]  <= 1'b1;
          tag_reg[up_idx]    <= up_tag;
          target_reg[up_idx] <= bus.ex_target;
          ctr_reg[up_idx]    <= bus.ex_is_jump ? 2'b11 : 2'b10;
        end
      end else if (bus.ex_is_jump) begin
        ctr_reg[up_idx]    <= 2'b11;
        target_reg[up_idx] <= bus.ex_target;
      end else if (bus.ex_taken) begin
        ctr_reg[up_idx]    <= (up_ctr == 2'b11) ? 2'b11 : up_ctr + 2'd1;
        target_reg[up_idx] <= bus.ex_target;
      end else begin
        ctr_reg[up_idx]    <= (up_ctr == 2'b00) ? 2'b00 : up_ctr - 2'd1;
      end
    end
  end

  // ---------------- Statistics ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_reg  <= '0;
      mispred_cnt_reg <= '0;
    end else begin
      if (bus.ex_valid) branch_cnt_reg  <= branch_cnt_reg + 32'd1;
      if (mis)          mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
    end
  end

  assign bus.branch_cnt  = branch_cnt_reg;
  assign bus.mispred_cnt = mispred_cnt_reg;
endmodule

// File: tb/tb_pc_next_gen.sv
// tb_pc_next_gen
// Directed test of pc_next_gen with hand-computed expectations.
module tb_pc_next_gen;
  logic clk;
  logic rst;
  int   assert_cnt;
  int   fail_cnt;

  pc_next_gen_if bus ();

  pc_next_gen #(.BTB_ENTRIES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic jmp, input logic [31:0] pc,
                        input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
    bus.ex_valid       = v;
    bus.ex_is_jump     = jmp;
    bus.ex_pc          = pc;
    bus.ex_taken       = tk;
    bus.ex_target      = tgt;
    bus.ex_pred_taken  = ptk;
    bus.ex_pred_target = ptgt;
  endtask

  task automatic no_ex();
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    assert_cnt = 0;
    fail_cnt   = 0;
    rst = 1'b1;
    bus.pc_cur       = 32'h0000_2FFC;
    bus.hazard_stall = 1'b1;
    bus.imem_busy    = 1'b0;
    // A mispredicting EX event during reset must be ignored.
    set_ex(1'b1, 1'b0, 32'h3010, 1'b1, 32'h3100, 1'b0, 32'h0);
    #1;
    check("rst_pc_next", bus.pc_next, 32'h3000);
    check("rst_stall", {31'b0, bus.stall}, 32'd0);
    check("rst_flush", {31'b0, bus.flush}, 32'd0);
    check("rst_pred_taken", {31'b0, bus.pred_taken}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    bus.hazard_stall = 1'b0;
    no_ex();
    #1;
    check("rst_branch_cnt", bus.branch_cnt, 32'd0);
    check("rst_mispred_cnt", bus.mispred_cnt, 32'd0);
    check("first_pc_next", bus.pc_next, 32'h3000);
    check("first_pred_taken", {31'b0, bus.pred_taken}, 32'd0);

    // Cold taken branch at 0x3010 -> redirect to 0x3100, allocate ctr=10
    bus.pc_cur = 32'h3004;
    set_ex(1'b1, 1'b0, 32'h3010, 1'b1, 32'h3100, 1'b0, 32'h3014);
    #1;
    check("cold_flush", {31'b0, bus.flush}, 32'd1);
    check("cold_pc_next", bus.pc_next, 32'h3100);
    tick();
    no_ex();
    bus.pc_cur = 32'h3010;
    #1;
    check("cold_mispred_cnt", bus.mispred_cnt, 32'd1);
    check("cold_branch_cnt", bus.branch_cnt, 32'd1);
    check("hit_pred_taken", {31'b0, bus.pred_taken}, 32'd1);
    check("hit_pred_target", bus.pred_target, 32'h3100);
    check("hit_pc_next", bus.pc_next, 32'h3100);

    // Not-taken, predicted taken, with both stalls: redirect wins.
    // Same-cycle lookup at 0x3010 still sees ctr=10.
    bus.hazard_stall = 1'b1;
    bus.imem_busy    = 1'b1;
    set_ex(1'b1, 1'b0, 32'h3010, 1'b0, 32'h0, 1'b1, 32'h3100);
    #1;
    check("rbs_stall", {31'b0, bus.stall}, 32'd0);
    check("rbs_flush", {31'b0, bus.flush}, 32'd1);
    check("rbs_pc_next", bus.pc_next, 32'h3014);
    check("nobypass_pred", {31'b0, bus.pred_taken}, 32'd1);
    tick();
    bus.hazard_stall = 1'b0;
    bus.imem_busy    = 1'b0;
    no_ex();
    #1;
    check("ctr01_pred", {31'b0, bus.pred_taken}, 32'd0);
    check("ctr01_target", bus.pred_target, 32'h3100);
    check("ctr01_pc_next", bus.pc_next, 32'h3014);

    // Two more correctly predicted not-taken -> ctr saturates at 00
    for (int i = 0; i < 2; i++) begin
      set_ex(1'b1, 1'b0, 32'h3010, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      check("nt_flush", {31'b0, bus.flush}, 32'd0);
      tick();
    end
    no_ex();
    #1;
    check("ctr00_pred", {31'b0, bus.pred_taken}, 32'd0);
    check("nt_branch_cnt", bus.branch_cnt, 32'd4);
    check("nt_mispred_cnt", bus.mispred_cnt, 32'd2);

    // Two taken (predicted not-taken) -> 01 then 10
    set_ex(1'b1, 1'b0, 32'h3010, 1'b1, 32'h3100, 1'b0, 32'h0);
    tick();
    no_ex();
    #1;
    check("sat_ctr01_pred", {31'b0, bus.pred_taken}, 32'd0);
    set_ex(1'b1, 1'b0, 32'h3010, 1'b1, 32'h3100, 1'b0, 32'h0);
    tick();
    no_ex();
    #1;
    check("ctr10_pred", {31'b0, bus.pred_taken}, 32'd1);
    check("ctr10_pc_next", bus.pc_next, 32'h3100);
    check("tk_branch_cnt", bus.branch_cnt, 32'd6);
    check("tk_mispred_cnt", bus.mispred_cnt, 32'd4);

    // Stall only
    bus.pc_cur = 32'h3020;
    bus.hazard_stall = 1'b1;
    #1;
    check("hz_stall", {31'b0, bus.stall}, 32'd1);
    check("hz_flush", {31'b0, bus.flush}, 32'd0);
    tick();
    check("hz_branch_cnt", bus.branch_cnt, 32'd6);
    check("hz_mispred_cnt", bus.mispred_cnt, 32'd4);
    bus.hazard_stall = 1'b0;
    bus.imem_busy    = 1'b1;
    #1;
    check("ib_stall", {31'b0, bus.stall}, 32'd1);
    // Stall with a correctly predicted EX branch: counters still advance
    set_ex(1'b1, 1'b0, 32'h3010, 1'b1, 32'h3100, 1'b1, 32'h3100);
    #1;
    check("stex_stall", {31'b0, bus.stall}, 32'd1);
    check("stex_flush", {31'b0, bus.flush}, 32'd0);
    tick();
    bus.imem_busy = 1'b0;
    no_ex();
    #1;
    check("stex_branch_cnt", bus.branch_cnt, 32'd7);
    check("stex_mispred_cnt", bus.mispred_cnt, 32'd4);

    // PC wrap
    bus.pc_cur = 32'hFFFF_FFFC;
    #1;
    check("wrap_pc_next", bus.pc_next, 32'h0000_0000);
    check("wrap_pred", {31'b0, bus.pred_taken}, 32'd0);

    // Aliasing: 0x3000 and 0x3040 share index 0
    set_ex(1'b1, 1'b0, 32'h3000, 1'b1, 32'h3200, 1'b0, 32'h0);
    #1;
    check("alias_redirect", bus.pc_next, 32'h3200);
    tick();
    no_ex();
    bus.pc_cur = 32'h3040;
    #1;
    check("alias_pred", {31'b0, bus.pred_taken}, 32'd0);
    check("alias_pc_next", bus.pc_next, 32'h3044);
    bus.pc_cur = 32'h3000;
    #1;
    check("alias_own_pc_next", bus.pc_next, 32'h3200);

    // Jump with wrong predicted target -> mispredict, allocate ctr=11
    set_ex(1'b1, 1'b1, 32'h3020, 1'b1, 32'h3400, 1'b1, 32'h3300);
    #1;
    check("jmp_flush", {31'b0, bus.flush}, 32'd1);
    check("jmp_pc_next", bus.pc_next, 32'h3400);
    tick();
    no_ex();
    bus.pc_cur = 32'h3020;
    #1;
    check("jmp_hit_pc_next", bus.pc_next, 32'h3400);
    check("jmp_branch_cnt", bus.branch_cnt, 32'd9);
    check("jmp_mispred_cnt", bus.mispred_cnt, 32'd6);

    // Mid-run reset: outputs gated, BTB and counters cleared
    rst = 1'b1;
    bus.pc_cur = 32'h3000;
    #1;
    check("rst2_pred", {31'b0, bus.pred_taken}, 32'd0);
    check("rst2_pred_target", bus.pred_target, 32'h3004);
    tick();
    rst = 1'b0;
    #1;
    check("rst2_lookup_pred", {31'b0, bus.pred_taken}, 32'd0);
    check("rst2_branch_cnt", bus.branch_cnt, 32'd0);
    check("rst2_mispred_cnt", bus.mispred_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/pc_next_gen.md
# pc_next_gen

Next-PC generator for the fetch stage of the pipelined RISC-V core; it is the producer side of the PC register's `pc_next`/`stall` interface. Each cycle it takes the current fetch address and drives the next one, using a small direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It resolves mispredictions reported by EX by redirecting fetch and flushing younger stages. It also keeps branch and mispredict statistics counters.

## Interface
- `BTB_ENTRIES`, 16: number of BTB entries; must be a power of two ≥ 2; IDX = log2(BTB_ENTRIES).
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `pc_cur`  in  32  current fetch PC from the PC register.
- `hazard_stall`  in  1  load-use hazard from decode.
- `imem_busy`  in  1  instruction memory not ready.
- `ex_valid`  in  1  EX holds a valid control-flow instruction this cycle.
- `ex_is_jump`  in  1  EX instruction is JAL/JALR; 0 means conditional branch.
- `ex_pc`  in  32  PC of the EX instruction.
- `ex_taken`  in  1  resolved direction; 1 for jumps.
- `ex_target`  in  32  resolved target address.
- `ex_pred_taken`  in  1  prediction carried with the EX instruction.
- `ex_pred_target`  in  32  predicted target carried with the EX instruction.
- `pc_next`  out  32  next fetch address to the PC register.
- `stall`  out  1  hold the PC register and IF/ID.
- `flush`  out  1  squash IF/ID and ID/EX.
- `pred_taken`  out  1  prediction for `pc_cur`; goes to IF/ID.
- `pred_target`  out  32  predicted target for `pc_cur`; goes to IF/ID.
- `branch_cnt`  out  32  resolved control-flow instructions since reset.
- `mispred_cnt`  out  32  mispredictions since reset.

## Operation
- **BTB entry fields:** valid, tag = pc[31:IDX+2], target[31:0], ctr[1:0].
- **Lookup:** index = pc[IDX+1:2].
- **Lookup (combinational on `pc_cur`):**
  - hit = valid && tag match.
  - `pred_taken` = hit && ctr[1].
  - `pred_target` = hit ? target : pc_cur+4.
- **Mispredict:** mis = ex_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
- **Next-PC priority:**
  1. rst: `pc_next` = pc_cur+4.
  2. mis: `pc_next` = ex_taken ? ex_target : ex_pc+4.
  3. `pred_taken`: `pc_next` = `pred_target`.
  4. Otherwise: `pc_next` = pc_cur+4.
- **All PC arithmetic:** 32-bit modulo; 0xFFFFFFFC+4 wraps to 0x00000000.
- **`stall`** = !rst && !mis && (hazard_stall || imem_busy). A redirect overrides any stall.
- **`flush`** = !rst && mis.
- **BTB update at posedge, when ex_valid && !rst, entry at ex_pc index:**
  - Tag miss, or entry invalid:
    - ex_taken: allocate: valid=1, tag, target=ex_target, ctr = ex_is_jump ? 2'b11 : 2'b10.
    - Not taken: no write.
  - Tag hit:
    - ex_is_jump: ctr=2'b11, target=ex_target.
    - Taken branch: ctr saturating +1 (max 11), target=ex_target.
    - Not-taken branch: ctr saturating −1 (min 00); target unchanged.
- **Same-cycle lookup and update to the same index:** the lookup sees the pre-update contents (no bypass).
- **Counters:**
  - `branch_cnt` += 1 on each ex_valid.
  - `mispred_cnt` += 1 on each mis.
  - Both wrap 0xFFFFFFFF→0.
- **`stall` and `ex_valid` in the same cycle:** the BTB update and counter increments still occur. EX has advanced independently of the fetch stall.

## Timing
- `pc_next`, `stall`, `flush`, `pred_*` are combinational from the current inputs and BTB state. Redirect takes effect at the PC register on the next edge (1-cycle redirect latency).
- BTB writes and counter updates are registered; they are visible to lookups from the cycle after the edge.
- **Reset (synchronous, any cycle including mid-redirect):**
  - Outputs during rst: stall=0, flush=0, pred_taken=0, pred_target=pc_cur+4.
  - Effect at the edge: all valid bits cleared, all ctr=2'b01, target and tag arrays undefined-but-unused, both counters cleared to 0.
  - A pending EX redirect is discarded.
- The PC register resets to 0x2FFC, so the first `pc_next` after reset release is 0x3000.

## Test plan
- **Reset:** hold rst 2 cycles with pc_cur=0x2FFC → pc_next=0x3000, stall=0, flush=0, branch_cnt=0, mispred_cnt=0, pred_taken=0.
- **Cold taken branch, then hit:**
  - ex_valid, ex_pc=0x3010, ex_taken=1, ex_target=0x3100, ex_pred_taken=0 → flush=1, pc_next=0x3100, mispred_cnt=1.
  - Next cycle pc_cur=0x3010 → pred_taken=1, pc_next=0x3100.
- **Counter hysteresis:** after the allocation above, 1 not-taken resolution at 0x3010 → ctr=01, lookup pred_taken=0. 2 more not-taken → ctr saturates at 00. 2 taken → ctr=10, predicts taken.
- **Redirect beats stall:** hazard_stall=1, imem_busy=1, and mis in the same cycle → stall=0, flush=1, pc_next=ex_pc+4 for a not-taken branch that was predicted taken.
- **Stall only:** hazard_stall=1, no EX event → stall=1, flush=0, counters unchanged. Same with imem_busy=1.
- **Wrap and aliasing:**
  - pc_cur=0xFFFFFFFC, no hit → pc_next=0x00000000.
  - With BTB_ENTRIES=16, a taken branch at 0x3000 and a lookup at 0x3040 (same index, different tag) → no hit, pred_taken=0.
